// File: rtl/cordic_sched.sv
// Sequential CORDIC vectoring engine: two requesters share one iterative core,
// round-robin arbitrated, one micro-rotation per clock, single response port.
module cordic_sched #(
  parameter int ITERS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic signed [11:0] req0_x,
  input  logic signed [11:0] req0_y,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic signed [11:0] req1_x,
  input  logic signed [11:0] req1_y,
  output logic               req1_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [15:0]        rsp_r,
  output logic [11:0]        rsp_t,
  output logic               busy
);

  localparam int IW = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]      iter;
  logic               rr_ptr;
  logic               id;
  logic signed [15:0] xa, ya;
  logic [11:0]        ta;

  logic               grant;
  logic               accept;
  logic               last;
  logic [11:0]        step;
  logic signed [15:0] xa_neg, ya_neg;
  logic signed [15:0] xa_nx, ya_nx;
  logic [11:0]        ta_nx;

  // rr_ptr only breaks ties; a lone requester always wins
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = rr_ptr;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign busy       = (state != IDLE);
  assign last       = (iter == IW'(ITERS - 1));

  // 1 << (11 - i) expressed as a right shift to keep the shift amount unsigned
  assign step   = 12'd2048 >> iter;
  assign xa_neg = -xa;
  assign ya_neg = -ya;

  always_comb begin
    xa_nx = xa;
    ya_nx = ya;
    ta_nx = ta;
    if (!ya[15]) begin
      xa_nx = xa + (ya >>> iter);
      ya_nx = ya + (xa_neg >>> iter);
      ta_nx = ta + step;
    end else begin
      xa_nx = xa + (ya_neg >>> iter);
      ya_nx = ya + (xa >>> iter);
      ta_nx = ta - step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter      <= '0;
      rr_ptr    <= 1'b0;
      id        <= 1'b0;
      xa        <= '0;
      ya        <= '0;
      ta        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_t     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xa     <= grant ? {req1_x, 4'b0} : {req0_x, 4'b0};
            ya     <= grant ? {req1_y, 4'b0} : {req0_y, 4'b0};
            ta     <= '0;
            iter   <= '0;
            id     <= grant;
            rr_ptr <= ~grant;
          end
        end
        RUN: begin
          xa   <= xa_nx;
          ya   <= ya_nx;
          ta   <= ta_nx;
          iter <= iter + IW'(1);
          if (last) begin
            rsp_r     <= xa_nx;
            rsp_t     <= ta_nx;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: scoreboard of modelled CORDIC results
// pushed on accept and compared on each response handshake.
module tb_cordic_sched;

  logic               clk = 1'b0;
  logic               reset;
  logic               req0_valid, req1_valid;
  logic signed [11:0] req0_x, req0_y, req1_x, req1_y;
  logic               req0_ready, req1_ready;
  logic               rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0]        rsp_r;
  logic [11:0]        rsp_t;

  cordic_sched #(.ITERS(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_t      (rsp_t),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] r;
    logic [11:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   id1_pops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic signed [11:0] x,
                                 input logic signed [11:0] y);
    exp_t               e;
    logic signed [15:0] xv, yv, xn, yn;
    logic [11:0]        tv, st;
    xv = {x, 4'b0};
    yv = {y, 4'b0};
    tv = '0;
    for (int i = 0; i < 12; i++) begin
      st = 12'd1 << (11 - i);
      if (yv >= 0) begin
        xn = xv + (yv >>> i);
        yn = yv + ((-xv) >>> i);
        tv = tv + st;
      end else begin
        xn = xv + ((-yv) >>> i);
        yn = yv + (xv >>> i);
        tv = tv - st;
      end
      xv = xn;
      yv = yn;
    end
    e.id = id;
    e.r  = xv;
    e.t  = tv;
    return e;
  endfunction

  // Observe the handshakes that complete on the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_x, req0_y));
      if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_x, req1_y));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_r",  32'(rsp_r),  32'(e.r));
          check("rsp_t",  32'(rsp_t),  32'(e.t));
          if (rsp_id) id1_pops++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit, input bit rand_ready);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    rsp_ready = 1'b1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int          n, n1, bad0, pops0;
    int          acc_cyc[4];
    logic        acc_id[4];
    logic [15:0] cap_r;
    logic [11:0] cap_t;
    logic        cap_id;
    logic        who;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp_ready = 1'b0;
    do_reset();

    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_r",     32'(rsp_r),     32'd0);
    check("rst_rsp_t",     32'(rsp_t),     32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    // Test 1: zero vector on req0
    req0_valid = 1'b1; req0_x = '0; req0_y = '0;
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'd1);
    check("t1_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check("t1_ready_drop", 32'(req0_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("t1_latency", 32'(n), 32'd12);
    check("t1_r",  32'(rsp_r),  32'd0);
    check("t1_t",  32'(rsp_t),  32'hFFF);
    check("t1_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("t1_valid_clr", 32'(rsp_valid), 32'd0);

    // Test 2: both requesters continuously valid from reset
    do_reset();
    req0_valid = 1'b1; req0_x = 12'sd300;  req0_y = -12'sd700;
    req1_valid = 1'b1; req1_x = -12'sd900; req1_y = 12'sd45;
    rsp_ready = 1'b1;
    #1;
    n = 0; n1 = 0;
    while (n1 < 4 && n < 200) begin
      if (req0_ready || req1_ready) begin
        acc_id[n1]  = req1_ready;
        acc_cyc[n1] = cyc;
        n1++;
      end
      tick();
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_accepts", 32'(n1), 32'd4);
    for (int k = 0; k < 4; k++) check("t2_grant_seq", 32'(acc_id[k]), 32'(k % 2));
    for (int k = 0; k < 3; k++) check("t2_spacing", 32'(acc_cyc[k+1] - acc_cyc[k]), 32'd14);
    drain("t2_drain", 60, 1'b0);

    // Test 3: random jobs, corner vectors first
    for (int j = 0; j < 200; j++) begin
      who = 1'($urandom_range(0, 1));
      if (j == 0) begin
        req0_x = -12'sd2048; req0_y = -12'sd2048; req1_x = -12'sd2048; req1_y = -12'sd2048;
      end else if (j == 1) begin
        req0_x = 12'sd2047; req0_y = 12'sd0; req1_x = 12'sd2047; req1_y = 12'sd0;
      end else begin
        req0_x = 12'($urandom); req0_y = 12'($urandom);
        req1_x = 12'($urandom); req1_y = 12'($urandom);
      end
      req0_valid = !who;
      req1_valid = who;
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 40) begin tick(); n++; end
      check("t3_ready", 32'(req0_ready || req1_ready), 32'd1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain("t3_drain", 80, 1'b1);
    end

    // Test 4: response held in DONE with both requesters pending
    req0_valid = 1'b1; req0_x = 12'sd1000; req0_y = 12'sd500;
    req1_valid = 1'b1; req1_x = -12'sd400; req1_y = -12'sd1200;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("t4_valid", 32'(rsp_valid), 32'd1);
    cap_r = rsp_r; cap_t = rsp_t; cap_id = rsp_id;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_r",  32'(rsp_r),  32'(cap_r));
      check("t4_hold_t",  32'(rsp_t),  32'(cap_t));
      check("t4_hold_id", 32'(rsp_id), 32'(cap_id));
      check("t4_ready0",  32'(req0_ready), 32'd0);
      check("t4_ready1",  32'(req1_ready), 32'd0);
      check("t4_busy",    32'(busy), 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("t4_valid_clr", 32'(rsp_valid), 32'd0);
    check("t4_r_kept",    32'(rsp_r), 32'(cap_r));
    check("t4_sb_empty",  32'(sb.size()), 32'd0);

    // Test 5: reset during iteration 5 aborts the req0 job
    req0_valid = 1'b1; req0_x = 12'sd1500; req0_y = 12'sd1500;
    #1;
    check("t5_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_r",     32'(rsp_r),     32'd0);
    check("t5_rsp_t",     32'(rsp_t),     32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_rr_req0", 32'(req0_ready), 32'd1);
    check("t5_rr_req1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rsp_valid) n++;
    end
    check("t5_no_rsp", 32'(n), 32'd0);

    // Test 6: req1 alone, three back-to-back jobs
    pops0 = id1_pops;
    req1_valid = 1'b1; req1_x = 12'sd123; req1_y = -12'sd456;
    rsp_ready = 1'b1;
    #1;
    n = 0; n1 = 0; bad0 = 0;
    while (n1 < 3 && n < 200) begin
      if (req0_ready) bad0++;
      if (req1_ready) begin
        n1++;
        req1_x = 12'($urandom);
        req1_y = 12'($urandom);
      end
      tick();
      n++;
    end
    req1_valid = 1'b0;
    drain("t6_drain", 60, 1'b0);
    check("t6_accepts",    32'(n1), 32'd3);
    check("t6_req0_ready", 32'(bad0), 32'd0);
    check("t6_id1_rsps",   32'(id1_pops - pops0), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
